ddc_fifo_reader: RTL

DDC_FIFO_READER -- requirements
Module: ddc_fifo_reader

---
 rtl/ddc_fifo_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ddc_fifo_reader.sv
// Drains paired left/right DDC sample FIFOs into a framed stream: header word, then FRAME_SETS sets of L_i, L_q, R_i, R_q.
// Build option DDC_RD_ROUND_EN selects round-half-up with positive saturation instead of plain truncation.
//
// state   | meaning
// IDLE    | waiting until both FIFOs hold data
// HDR     | presenting the frame header word
// FETCH   | paired read strobe as soon as both FIFOs are non-empty
// LATCH   | FIFO dout valid; capture all four words
// SEND    | presenting the four held words in order
module ddc_fifo_reader #(
  parameter int DATA_WIDTH = 34,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAME_SETS = 4
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  empty_L,
  input  logic                  empty_R,
  input  logic [DATA_WIDTH-1:0] din_L_i,
  input  logic [DATA_WIDTH-1:0] din_L_q,
  input  logic [DATA_WIDTH-1:0] din_R_i,
  input  logic [DATA_WIDTH-1:0] din_R_q,
  output logic                  rd_en_L,
  output logic                  rd_en_R,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof
);

  localparam int        SH       = DATA_WIDTH - OUT_WIDTH;
  localparam logic [7:0] LAST_SET = 8'(FRAME_SETS - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_LATCH, S_SEND} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_both_avail;
  logic                  w_last_set;
  logic                  w_rd_en;
  logic [OUT_WIDTH-1:0]  r_m_data;
  logic                  r_m_valid;
  logic                  r_m_sof;
  logic                  r_m_eof;
  logic [15:0]           r_frame_cnt;
  logic [7:0]            r_set_cnt;
  logic [1:0]            r_idx;
  logic [OUT_WIDTH-1:0]  r_hold [4];

`ifdef DDC_RD_ROUND_EN
  localparam logic [DATA_WIDTH:0] RND = (DATA_WIDTH+1)'(1) << (SH - 1);

  // One guard bit above the sign catches the only possible overflow: rounding up past max positive.
  function automatic logic [OUT_WIDTH-1:0] conv(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH:0] sum;
    sum = {d[DATA_WIDTH-1], d} + RND;
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      conv = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else
      conv = OUT_WIDTH'(sum >> SH);
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] conv(input logic [DATA_WIDTH-1:0] d);
    conv = OUT_WIDTH'($signed(d) >>> SH);
  endfunction
`endif

  assign w_both_avail = !empty_L && !empty_R;
  assign w_last_set   = (r_set_cnt == LAST_SET);

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_both_avail) w_state_nxt = S_HDR;
      S_HDR:   if (m_ready) w_state_nxt = S_FETCH;
      S_FETCH: if (w_both_avail) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_SEND;
      S_SEND:  if (m_ready && r_idx == 2'd3) w_state_nxt = w_last_set ? S_IDLE : S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = (r_state == S_FETCH) && w_both_avail;
  end

  assign rd_en_L = w_rd_en;
  assign rd_en_R = w_rd_en;

  // Stream registers are loaded on the edge entering each presenting state so m_* stay registered.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_sof     <= 1'b0;
      r_m_eof     <= 1'b0;
      r_frame_cnt <= '0;
      r_set_cnt   <= '0;
      r_idx       <= '0;
      for (int k = 0; k < 4; k++) r_hold[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_both_avail) begin
            r_m_data  <= OUT_WIDTH'({16'hDDC0, r_frame_cnt});
            r_m_valid <= 1'b1;
            r_m_sof   <= 1'b1;
          end
        end
        S_HDR: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_sof   <= 1'b0;
          end
        end
        S_LATCH: begin
          r_hold[0] <= conv(din_L_i);
          r_hold[1] <= conv(din_L_q);
          r_hold[2] <= conv(din_R_i);
          r_hold[3] <= conv(din_R_q);
          r_m_data  <= conv(din_L_i);
          r_m_valid <= 1'b1;
          r_idx     <= 2'd0;
        end
        S_SEND: begin
          if (m_ready) begin
            if (r_idx == 2'd3) begin
              r_m_valid <= 1'b0;
              r_m_eof   <= 1'b0;
              if (w_last_set) begin
                r_set_cnt   <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
              end else begin
                r_set_cnt <= r_set_cnt + 8'd1;
              end
            end else begin
              r_idx    <= r_idx + 2'd1;
              r_m_data <= r_hold[r_idx + 2'd1];
              r_m_eof  <= (r_idx == 2'd2) && w_last_set;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_sof   = r_m_sof;
  assign m_eof   = r_m_eof;

endmodule
